// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported unified memory between instruction fetch and data access.
// One registered access per grant, fixed read latency, one-cycle done pulse to the owner.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT    = 0,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    input  logic        dm_req,
    input  logic        dm_wr,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    input  logic [15:0] mem_rdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [15:0] rd_data,
    output logic        if_done,
    output logic        dm_done,
    output logic        if_stall,
    output logic        dm_stall,
    output logic        err
);

    localparam int unsigned CntW    = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam int unsigned StarveW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CntW-1:0]    LatInit   = CntW'(MEM_LAT);
    localparam logic [StarveW-1:0] StarveLim = StarveW'(STARVE_MAX);

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} stateT;

    stateT               stateQ, stateD;
    logic                ownerDmQ, ownerDmD;
    logic                memEnQ, memEnD;
    logic                wrQ, wrD;
    logic                errQ, errD;
    logic [CntW-1:0]     cntQ, cntD;
    logic [StarveW-1:0]  starveQ, starveD;
    logic [15:0]         addrQ, addrD;
    logic [15:0]         wdataQ, wdataD;
    logic [15:0]         rdDataQ, rdDataD;
    logic                anyReq, forceIf, grantDm, ownerReq;

    assign anyReq   = if_req | dm_req;
    // IF overrides DM only once it has lost STARVE_MAX grants in a row.
    assign forceIf  = if_req & (starveQ == StarveLim);
    assign grantDm  = dm_req & ~forceIf;
    assign ownerReq = ownerDmQ ? dm_req : if_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle:           if (anyReq) stateD = StAccess;
            StAccess, StWait: stateD = (cntQ == '0) ? StResp : StWait;
            StResp:           stateD = StIdle;
            default:          stateD = StIdle;
        endcase
    end

    always_comb begin
        mem_en    = memEnQ;
        mem_wr    = memEnQ & wrQ;
        mem_addr  = addrQ;
        mem_wdata = wdataQ;
        rd_data   = rdDataQ;
        if_done   = (stateQ == StResp) & ~ownerDmQ;
        dm_done   = (stateQ == StResp) & ownerDmQ;
        if_stall  = if_req & ~if_done;
        dm_stall  = dm_req & ~dm_done;
        err       = errQ;
    end

    always_comb begin
        ownerDmD = ownerDmQ;
        memEnD   = 1'b0;
        wrD      = wrQ;
        errD     = errQ;
        cntD     = cntQ;
        starveD  = starveQ;
        addrD    = addrQ;
        wdataD   = wdataQ;
        rdDataD  = rdDataQ;
        unique case (stateQ)
            StIdle: begin
                if (anyReq) begin
                    memEnD   = 1'b1;
                    ownerDmD = grantDm;
                    addrD    = grantDm ? dm_addr : if_addr;
                    wrD      = grantDm & dm_wr;
                    wdataD   = grantDm ? dm_wdata : 16'h0000;
                    cntD     = LatInit;
                    if (grantDm && if_req) begin
                        starveD = (starveQ == StarveLim) ? starveQ : starveQ + StarveW'(1);
                    end else begin
                        starveD = '0;
                    end
                end
            end
            StAccess, StWait: begin
                if (!ownerReq) errD = 1'b1;
                if (cntQ == '0) begin
                    rdDataD = (ownerDmQ && wrQ) ? 16'h0000 : mem_rdata;
                end else begin
                    cntD = cntQ - CntW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ownerDmQ <= 1'b0;
            memEnQ   <= 1'b0;
            wrQ      <= 1'b0;
            errQ     <= 1'b0;
            cntQ     <= '0;
            starveQ  <= '0;
            addrQ    <= 16'h0000;
            wdataQ   <= 16'h0000;
            rdDataQ  <= 16'h0000;
        end else begin
            ownerDmQ <= ownerDmD;
            memEnQ   <= memEnD;
            wrQ      <= wrD;
            errQ     <= errD;
            cntQ     <= cntD;
            starveQ  <= starveD;
            addrQ    <= addrD;
            wdataQ   <= wdataD;
            rdDataQ  <= rdDataD;
        end
    end

endmodule
